tx_mac: RTL and testbench
=========================

// Module: tx_mac
// PURPOSE
//  Per-port transmit MAC on the crossbar output side: takes the crossbar tx_data/tx_ctrl byte stream and emits GMII frames.
//  Each frame gets preamble, SFD, zero pad to minimum size, CRC32 FCS and inter-frame gap.
//  An internal byte FIFO absorbs the 8-byte preamble delay and back-to-back frames; frames that may not fit are dropped whole.
// PARAMETERS
//  P_FIFO_ADDR_WIDTH  8     FIFO depth = 2**P_FIFO_ADDR_WIDTH entries of {last, byte[7:0]}
//  P_MAX_LEN          200   max payload bytes kept per frame; must be < 2**P_FIFO_ADDR_WIDTH
//  P_IFG              12    idle cycles after each frame
// PORTS
//  clk_i         in   1  single clock
//  rstn_i        in   1  asynchronous, active-low reset
//  tx_data_i     in   8  payload byte from crossbar, valid while tx_ctrl_i=1
//  tx_ctrl_i     in   1  1 = valid byte; frame = contiguous run of 1s, ends when it falls
//  gmii_txd_o    out  8  GMII transmit data
//  gmii_tx_en_o  out  1  GMII transmit enable
//  gmii_tx_er_o  out  1  GMII transmit error
//  frame_drop_o  out  1  one-cycle pulse when a whole input frame is discarded
//  busy_o        out  1  1 while FSM is not IDLE or FIFO is non-empty
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFO empty, FSM IDLE. Takes effect mid-frame.
//  - After release with tx_ctrl_i=1, ignore input until tx_ctrl_i has been 0 for one cycle.
//  Input: 1-cycle stage register holds the byte.
//  - Byte is written to the FIFO next cycle with last = ~tx_ctrl_i of that cycle.
//  Admission, checked on the first byte of each frame (tx_ctrl_i rises):
//  - If free entries < P_MAX_LEN+1, discard the whole frame and pulse frame_drop_o on that cycle.
//  - A dropped frame produces nothing on GMII.
//  Truncation: byte number P_MAX_LEN is written with last=1.
//  - Remaining bytes are discarded until tx_ctrl_i falls.
//  - The frame is marked truncated: gmii_tx_er_o=1 on its final FCS byte.
//  FSM states, all outputs registered:
//  - IDLE:  tx_en=0, txd=0. Go to PRE when the FIFO is non-empty.
//  - PRE:   7 cycles of 0x55, tx_en=1.
//  - SFD:   1 cycle of 0xD5.
//  - DATA:  pop one FIFO byte per cycle.
//    - On the last byte: go to PAD if payload count < 60, else go to FCS.
//  - PAD:   0x00 bytes until payload count = 60.
//  - FCS:   4 cycles, CRC LSB byte first.
//  - IFG:   P_IFG cycles with tx_en=0, then IDLE. Re-entry to PRE is allowed directly if the FIFO is non-empty.
//  Latency: first input byte on tx_data_i at cycle N -> first 0x55 on gmii_txd_o at cycle N+3.
//  CRC32 rules:
//  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
//  - Covers payload and pad; FCS = ~crc, sent LSB byte first.
//  - CRC is reset in SFD.
//  Payload counter: 11 bits, saturating.
//  Underflow: FIFO empty in DATA before a last byte is seen.
//  - Drive gmii_tx_er_o=1 with tx_en=1 for 1 cycle, then go to IFG; no FCS is sent.
//  - Discard FIFO entries up to and including the next last=1.
//  FIFO full/empty: distinguish with an extra pointer bit.
//  - Simultaneous push and pop on a full FIFO is legal; the admission rule makes a true overflow unreachable.
//  - Pointer wrap-around is modulo 2**P_FIFO_ADDR_WIDTH.
// TESTING
//  1. 8-byte frame 0xAA..0xB1 -> 7x0x55, 0xD5, AA..B1, 52x0x00, 4 FCS bytes.
//     - tx_en high 72 cycles, FCS matches a zlib crc32 model, then 12 idle cycles.
//  2. 100-byte frame of incrementing bytes -> no pad; tx_en high 112 cycles; FCS matches model; tx_er stays 0.
//  3. 5 frames of 8 bytes with 1-cycle gaps -> all 5 sent in order, each separated by exactly 12 idle cycles.
//     - frame_drop_o stays 0.
//  4. P_FIFO_ADDR_WIDTH=6, P_MAX_LEN=40, back-to-back 40-byte frames -> a frame is dropped when free space < 41.
//     - frame_drop_o pulses once per dropped frame; accepted frames are intact.
//  5. 250-byte frame with P_MAX_LEN=200 -> 200 payload bytes sent; gmii_tx_er_o=1 on the 4th FCS byte only.
//  6. rstn_i low for 1 cycle mid-DATA -> outputs 0 at once, busy_o=0.
//     - The rest of the in-flight input frame is ignored; the next frame is sent correctly.

Source files
------------

// File: rtl/tx_mac.sv
// tx_mac: turns the crossbar tx_data/tx_ctrl byte stream into GMII frames with
// preamble, SFD, zero pad, CRC32 FCS and inter-frame gap. Frames that might not fit the FIFO are dropped whole.
module tx_mac #(
    parameter int P_FIFO_ADDR_WIDTH = 8,
    parameter int P_MAX_LEN         = 200,
    parameter int P_IFG             = 12
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_ctrl_i,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       frame_drop_o,
    output logic       busy_o
);
    localparam int AW    = P_FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(P_IFG + 8);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PRE  = 4'd1;
    localparam logic [3:0] S_SFD  = 4'd2;
    localparam logic [3:0] S_DATA = 4'd3;
    localparam logic [3:0] S_PAD  = 4'd4;
    localparam logic [3:0] S_FCS  = 4'd5;
    localparam logic [3:0] S_UFL  = 4'd6;
    localparam logic [3:0] S_IFG  = 4'd7;

    logic          armed, prev_ctrl, in_acc, s_vld, s_force;
    logic [7:0]    s_data;
    logic [AW:0]   in_cnt, cnt_next;
    logic [AW+1:0] used, free;
    logic          start, load;

    logic [9:0]    mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic [9:0]    head;
    logic          empty, push, pop;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [10:0]   paycnt, pay_inc;
    logic [31:0]   crc_q, fcs;
    logic          cur_last, cur_trunc, disc, fetch;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Stage byte counts as occupied so admission never overcommits the FIFO.
    assign start        = tx_ctrl_i & ~prev_ctrl & armed;
    assign used         = {1'b0, wptr - rptr} + {{(AW+1){1'b0}}, s_vld};
    assign free         = (AW+2)'(DEPTH) - used;
    assign frame_drop_o = start && (free < (AW+2)'(P_MAX_LEN + 1));
    assign cnt_next     = start ? (AW+1)'(1) : in_cnt + (AW+1)'(1);
    assign load         = start ? ~frame_drop_o
                                : (tx_ctrl_i & prev_ctrl & in_acc & (in_cnt < (AW+1)'(P_MAX_LEN)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            armed     <= 1'b0;
            prev_ctrl <= 1'b0;
            in_acc    <= 1'b0;
            s_vld     <= 1'b0;
            s_force   <= 1'b0;
            s_data    <= '0;
            in_cnt    <= '0;
        end else begin
            prev_ctrl <= tx_ctrl_i;
            armed     <= armed | ~tx_ctrl_i;
            if (start) in_acc <= ~frame_drop_o;
            s_vld <= load;
            if (load) begin
                s_data  <= tx_data_i;
                s_force <= (cnt_next == (AW+1)'(P_MAX_LEN));
                in_cnt  <= cnt_next;
            end
        end
    end

    // Entry = {truncated, last, byte}; a forced last with input still running marks truncation.
    assign push  = s_vld;
    assign empty = (wptr == rptr);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[AW-1:0]] <= {s_force & tx_ctrl_i, s_force | ~tx_ctrl_i, s_data};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    assign fetch   = (state == S_SFD) || (state == S_DATA && !cur_last);
    assign pop     = !empty && (disc || fetch);
    assign pay_inc = (paycnt == 11'h7ff) ? paycnt : paycnt + 11'd1;
    assign fcs     = ~crc_q;
    assign busy_o  = (state != S_IDLE) || !empty;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            paycnt       <= '0;
            crc_q        <= '1;
            cur_last     <= 1'b0;
            cur_trunc    <= 1'b0;
            disc         <= 1'b0;
            gmii_txd_o   <= '0;
            gmii_tx_en_o <= 1'b0;
            gmii_tx_er_o <= 1'b0;
        end else begin
            if (disc && !empty && head[8]) disc <= 1'b0;
            case (state)
                S_IDLE: if (!empty && !disc) begin
                    state        <= S_PRE;
                    cnt          <= '0;
                    gmii_txd_o   <= 8'h55;
                    gmii_tx_en_o <= 1'b1;
                end
                S_PRE: if (cnt == CW'(6)) begin
                    state      <= S_SFD;
                    gmii_txd_o <= 8'hD5;
                    crc_q      <= '1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                S_SFD, S_DATA, S_PAD: begin
                    if (fetch) begin
                        if (empty) begin
                            state        <= S_UFL;
                            gmii_txd_o   <= 8'h00;
                            gmii_tx_er_o <= 1'b1;
                            disc         <= 1'b1;
                        end else begin
                            state      <= S_DATA;
                            gmii_txd_o <= head[7:0];
                            crc_q      <= crc_byte(crc_q, head[7:0]);
                            paycnt     <= (state == S_SFD) ? 11'd1 : pay_inc;
                            cur_last   <= head[8];
                            cur_trunc  <= head[9];
                        end
                    end else if (paycnt < 11'd60) begin
                        state      <= S_PAD;
                        gmii_txd_o <= 8'h00;
                        crc_q      <= crc_byte(crc_q, 8'h00);
                        paycnt     <= pay_inc;
                    end else begin
                        state      <= S_FCS;
                        gmii_txd_o <= fcs[7:0];
                        cnt        <= '0;
                    end
                end
                S_FCS: if (cnt == CW'(3)) begin
                    state        <= S_IFG;
                    cnt          <= '0;
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b0;
                    gmii_tx_er_o <= 1'b0;
                end else begin
                    cnt          <= cnt + CW'(1);
                    gmii_txd_o   <= 8'(fcs >> (8 * (int'(cnt) + 1)));
                    gmii_tx_er_o <= cur_trunc && (cnt == CW'(2));
                end
                S_UFL: begin
                    state        <= S_IFG;
                    cnt          <= '0;
                    gmii_tx_en_o <= 1'b0;
                    gmii_tx_er_o <= 1'b0;
                end
                S_IFG: if (cnt == CW'(P_IFG - 1)) begin
                    if (!empty && !disc) begin
                        state        <= S_PRE;
                        cnt          <= '0;
                        gmii_txd_o   <= 8'h55;
                        gmii_tx_en_o <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_mac.sv
// Randomized scoreboard bench for tx_mac: a timeline model predicts admission, frame start
// cycles and wire bytes (table-driven CRC32); a monitor checks every GMII frame against it.
module tb_tx_mac;
    localparam int AW    = 8;
    localparam int MAXL  = 200;
    localparam int IFG   = 12;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int start;
        int len;
        bit trunc;
    } frame_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ctrl = 1'b0;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, frame_drop, busy;

    int checks = 0, errors = 0;
    int cyc = 0;
    int exp_drops = 0, seen_drops = 0, idle_bad = 0;
    int prev_end = -1000;
    logic [31:0] crc_tbl [256];
    logic [7:0]  exp_bytes [$];
    frame_t      exp_q [$];
    int acc_n [$], acc_l [$], acc_s [$];

    tx_mac #(.P_FIFO_ADDR_WIDTH(AW), .P_MAX_LEN(MAXL), .P_IFG(IFG)) dut (
        .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_ctrl_i(tx_ctrl),
        .gmii_txd_o(gmii_txd), .gmii_tx_en_o(gmii_tx_en), .gmii_tx_er_o(gmii_tx_er),
        .frame_drop_o(frame_drop), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Entries held at cycle t: bytes taken in before t minus bytes already fetched for the wire.
    function automatic int occ(input int t);
        int o = 0;
        for (int i = 0; i < acc_n.size(); i++)
            o += clamp(t - acc_n[i], acc_l[i]) - clamp(t - acc_s[i] - 7, acc_l[i]);
        return o;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_bytes.delete();
        acc_n.delete();
        acc_l.delete();
        acc_s.delete();
        prev_end = -1000;
    endtask

    task automatic send_frame(input int len, input int mode, input int gap, input int rst_at);
        logic [7:0]  pay [$];
        logic [7:0]  b;
        logic [31:0] c;
        int n, kept, p, s;
        bit dexp;
        for (int j = 0; j < len; j++) begin
            case (mode)
                0:       b = 8'hAA + 8'(j);
                1:       b = 8'(j);
                default: b = 8'($urandom);
            endcase
            pay.push_back(b);
        end
        n = cyc;
        dexp = (DEPTH - occ(n)) < (MAXL + 1);
        if (dexp) exp_drops++;
        else begin
            kept = (len < MAXL) ? len : MAXL;
            p = (kept < 60) ? 60 : kept;
            s = (n + 3 > prev_end + IFG + 1) ? n + 3 : prev_end + IFG + 1;
            prev_end = s + 8 + p + 3;
            acc_n.push_back(n);
            acc_l.push_back(kept);
            acc_s.push_back(s);
            repeat (7) exp_bytes.push_back(8'h55);
            exp_bytes.push_back(8'hD5);
            c = 32'hFFFFFFFF;
            for (int k = 0; k < p; k++) begin
                b = (k < kept) ? pay[k] : 8'h00;
                exp_bytes.push_back(b);
                c = crc_tbl[c[7:0] ^ b] ^ (c >> 8);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
            exp_q.push_back('{start: s, len: 12 + p, trunc: (len > MAXL)});
        end
        for (int j = 0; j < len; j++) begin
            rstn    = 1'b1;
            tx_ctrl = 1'b1;
            tx_data = pay[j];
            if (j == 0) begin
                #1;
                chk("frame_drop", {31'b0, frame_drop}, {31'b0, dexp});
            end
            if (rst_at > 0 && j == rst_at) begin
                rstn = 1'b0;
                #1;
                chk("reset_outputs", {20'b0, gmii_txd, gmii_tx_en, gmii_tx_er, frame_drop, busy}, 32'h0);
                model_reset();
            end
            tick();
        end
        rstn    = 1'b1;
        tx_ctrl = 1'b0;
        tx_data = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic drain();
        int lim = 0;
        while (cyc <= prev_end + IFG + 2 && lim < 20000) begin
            tick();
            lim++;
        end
        chk("busy_after_drain", {31'b0, busy}, 32'h0);
        chk("frames_outstanding", exp_q.size(), 32'h0);
    endtask

    initial begin : monitor
        frame_t     f;
        bit         inf = 1'b0;
        int         pos = 0, bad = 0, bpos = 0;
        logic [7:0] eb, bgot, bexp;
        bit         erx;
        f = '{start: 0, len: 0, trunc: 1'b0};
        forever begin
            @(negedge clk);
            if (!rstn) begin
                inf = 1'b0;
                continue;
            end
            if (frame_drop) seen_drops++;
            if (gmii_tx_en) begin
                if (!inf) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: tx_en rose at cycle %0d with nothing expected", cyc);
                        f = '{start: cyc, len: 0, trunc: 1'b0};
                    end else begin
                        f = exp_q.pop_front();
                        if (cyc != f.start) begin
                            errors++;
                            $display("FAIL frame_start: got cycle %0d expected cycle %0d", cyc, f.start);
                        end
                    end
                    inf = 1'b1;
                    pos = 0;
                    bad = 0;
                end
                if (pos < f.len) begin
                    eb  = exp_bytes.pop_front();
                    erx = f.trunc && (pos == f.len - 1);
                    if (gmii_txd !== eb || gmii_tx_er !== erx) begin
                        if (bad == 0) begin
                            bpos = pos;
                            bgot = gmii_txd;
                            bexp = eb;
                        end
                        bad++;
                    end
                end
                pos++;
            end else begin
                if (gmii_txd !== 8'h00 || gmii_tx_er !== 1'b0) idle_bad++;
                if (inf) begin
                    checks++;
                    if (pos != f.len) begin
                        errors++;
                        $display("FAIL frame_length: got %0d tx_en cycles expected %0d", pos, f.len);
                    end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame_bytes: %0d bad, first at %0d got %0h expected %0h (er/byte)",
                                 bad, bpos, bgot, bexp);
                    end
                    for (int k = pos; k < f.len; k++) void'(exp_bytes.pop_front());
                    inf = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        int len, gap;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = 32'(i);
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            crc_tbl[i] = r;
        end
        rstn    = 1'b0;
        tx_ctrl = 1'b1;
        tx_data = 8'h5A;
        #1;
        chk("reset_state", {20'b0, gmii_txd, gmii_tx_en, gmii_tx_er, frame_drop, busy}, 32'h0);
        repeat (3) tick();
        rstn = 1'b1;
        // Input already running at reset release must be ignored.
        repeat (6) begin
            tx_data = 8'($urandom);
            tick();
        end
        tx_ctrl = 1'b0;
        tick();
        chk("ignored_after_reset", {31'b0, busy}, 32'h0);

        send_frame(8, 0, 1, 0);
        drain();
        send_frame(100, 1, 1, 0);
        drain();
        repeat (5) send_frame(8, 0, 1, 0);
        drain();
        send_frame(250, 2, 3, 0);
        drain();
        repeat (12) send_frame(40, 2, 1, 0);
        drain();
        send_frame(100, 2, 1, 50);
        send_frame(20, 2, 2, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       begin len = $urandom_range(150, 250); gap = $urandom_range(1, 40); end
                1:       begin len = $urandom_range(40, 100);  gap = $urandom_range(1, 20); end
                default: begin len = $urandom_range(1, 30);    gap = $urandom_range(1, 5);  end
            endcase
            send_frame(len, 2, gap, 0);
        end
        drain();

        chk("drop_pulses", seen_drops, exp_drops);
        chk("idle_lines_clean", idle_bad, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
